// File: rtl/npc_bus_pkg.sv
// Shared types and constants for the NPC memory bus: arbiter FSM states,
// default bus widths and fixed requester indices.
package npc_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } bus_state_e;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;

    localparam int REQ_IFU = 0;
    localparam int REQ_LSU = 1;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set valid bit searching upward from ptr, wrapping.
// Purely combinational.
module rr_pick #(
    parameter  int NR_REQ = 2,
    localparam int PW     = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
    input  logic [NR_REQ-1:0] valid,
    input  logic [PW-1:0]     ptr,
    output logic              any,
    output logic [PW-1:0]     idx
);

    // Walk from farthest to nearest so the slot closest to ptr wins last.
    always_comb begin
        any = |valid;
        idx = '0;
        for (int k = NR_REQ - 1; k >= 0; k--) begin
            if (valid[(int'(ptr) + k) % NR_REQ])
                idx = PW'((int'(ptr) + k) % NR_REQ);
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port among NR_REQ requesters,
// one outstanding transaction, response routed back by owner index.
module mem_bus_arbiter
    import npc_bus_pkg::*;
#(
    parameter int NR_REQ = 2,
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NR_REQ-1:0]          req_valid,
    output logic [NR_REQ-1:0]          req_ready,
    input  logic [NR_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NR_REQ-1:0]          req_wen,
    input  logic [NR_REQ*DATA_W-1:0]   req_wdata,
    input  logic [NR_REQ*DATA_W/8-1:0] req_wmask,
    output logic [NR_REQ-1:0]          rsp_valid,
    input  logic [NR_REQ-1:0]          rsp_ready,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_err,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_wen,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic [DATA_W/8-1:0]        mem_wmask,
    input  logic                       mem_rsp_valid,
    output logic                       mem_rsp_ready,
    input  logic [DATA_W-1:0]          mem_rdata,
    input  logic                       mem_err
);

    localparam int MW = DATA_W / 8;
    localparam int PW = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

    bus_state_e          r_state, w_next;
    logic [PW-1:0]       r_owner, r_ptr;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic [MW-1:0]       r_wmask;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;

    logic                w_any;
    logic [PW-1:0]       w_idx;
    logic                w_accept;
    logic                w_rsp_fire;

    rr_pick #(.NR_REQ(NR_REQ)) u_pick (
        .valid (req_valid),
        .ptr   (r_ptr),
        .any   (w_any),
        .idx   (w_idx)
    );

    assign w_accept   = (r_state == ST_IDLE) && w_any;
    assign w_rsp_fire = (r_state == ST_RESP) && rsp_ready[r_owner];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_any)          w_next = ST_ISSUE;
            ST_ISSUE: if (mem_req_ready)  w_next = ST_WAIT;
            ST_WAIT:  if (mem_rsp_valid)  w_next = ST_RESP;
            ST_RESP:  if (w_rsp_fire)     w_next = ST_IDLE;
            default:                      w_next = ST_IDLE;
        endcase
    end

    // req_ready is gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        req_ready     = '0;
        rsp_valid     = '0;
        mem_req_valid = (r_state == ST_ISSUE);
        mem_rsp_ready = (r_state == ST_WAIT);
        if (rst_n && w_accept)      req_ready[w_idx]   = 1'b1;
        if (r_state == ST_RESP)     rsp_valid[r_owner] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= '0;
            r_ptr   <= '0;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_owner <= w_idx;
                r_addr  <= req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
                r_wen   <= req_wen[w_idx];
                r_wdata <= req_wdata[int'(w_idx)*DATA_W +: DATA_W];
                r_wmask <= req_wmask[int'(w_idx)*MW +: MW];
            end
            if ((r_state == ST_WAIT) && mem_rsp_valid) begin
                r_rdata <= mem_rdata;
                r_err   <= mem_err;
            end
            if (w_rsp_fire)
                r_ptr <= (r_owner == PW'(NR_REQ - 1)) ? '0 : r_owner + PW'(1);
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wen   = r_wen;
    assign mem_wdata = r_wdata;
    assign mem_wmask = r_wmask;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized self-checking bench for mem_bus_arbiter with a round-robin
// reference model and a cycle-stepped memory/requester driver.
module tb_mem_bus_arbiter;
    import npc_bus_pkg::*;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_wen;
    logic [N*DW-1:0] req_wdata;
    logic [N*MW-1:0] req_wmask;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready = '0;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            mem_req_valid;
    logic            mem_req_ready = 1'b0;
    logic [AW-1:0]   mem_addr;
    logic            mem_wen;
    logic [DW-1:0]   mem_wdata;
    logic [MW-1:0]   mem_wmask;
    logic            mem_rsp_valid = 1'b0;
    logic            mem_rsp_ready;
    logic [DW-1:0]   mem_rdata = '0;
    logic            mem_err = 1'b0;

    logic [AW-1:0]   b_addr  [N];
    logic            b_wen   [N];
    logic [DW-1:0]   b_wdata [N];
    logic [MW-1:0]   b_wmask [N];

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;

    always #5 clk = ~clk;

    for (genvar n = 0; n < N; n++) begin : g_pack
        assign req_addr[n*AW +: AW]  = b_addr[n];
        assign req_wen[n]            = b_wen[n];
        assign req_wdata[n*DW +: DW] = b_wdata[n];
        assign req_wmask[n*MW +: MW] = b_wmask[n];
    end

    mem_bus_arbiter #(.NR_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_wen       (req_wen),
        .req_wdata     (req_wdata),
        .req_wmask     (req_wmask),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_ready (mem_rsp_ready),
        .mem_rdata     (mem_rdata),
        .mem_err       (mem_err)
    );

    // Spec rule: first valid requester at or after ptr, wrapping.
    function automatic int model_pick(input int ptr, input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] lane(input int g);
        logic [N-1:0] v;
        v = '0;
        if (g >= 0 && g < N) v[g] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        m_ptr = 0;
    endtask

    task automatic rand_fields();
        for (int n = 0; n < N; n++) begin
            b_addr[n]  = $urandom;
            b_wen[n]   = 1'($urandom_range(0, 1));
            b_wdata[n] = $urandom;
            b_wmask[n] = MW'($urandom);
        end
    endtask

    // Runs one full transaction from IDLE back to IDLE; returns what it saw.
    // bad counts protocol-level violations spotted along the way.
    task automatic txn(input logic [N-1:0] vld, input int iss_w, input int rsp_w,
                       input int stall, input logic [DW-1:0] rd, input logic er,
                       input bit early, output int g, output logic [AW-1:0] a,
                       output logic we, output logic [DW-1:0] wd,
                       output logic [MW-1:0] wm, output logic [N-1:0] rv,
                       output logic [DW-1:0] od, output logic oe, output int bad);
        int cyc;
        logic [AW-1:0] a0;
        logic [DW-1:0] wd0;
        bad = 0; g = -1; a = '0; we = 1'b0; wd = '0; wm = '0;
        rv = '0; od = '0; oe = 1'b0;
        req_valid = vld;
        #1;
        cyc = 0;
        while (req_ready == '0 && cyc < 20) begin
            tick();
            cyc++;
        end
        if (req_ready == '0) begin
            bad++;
            req_valid = '0;
            return;
        end
        if ($countones(req_ready) != 1 || mem_req_valid !== 1'b0 || mem_rsp_ready !== 1'b0) bad++;
        for (int n = 0; n < N; n++) if (req_ready[n]) g = n;
        tick();
        // Inputs are don't-care once accepted: scramble them.
        b_addr[g]  = $urandom;
        b_wdata[g] = $urandom;
        a0  = mem_addr;
        wd0 = mem_wdata;
        for (int k = 0; k < iss_w; k++) begin
            mem_req_ready = 1'b0;
            mem_rsp_valid = early;
            mem_rdata = $urandom;
            #1;
            if (mem_req_valid !== 1'b1 || mem_addr !== a0 || mem_wdata !== wd0 ||
                mem_rsp_ready !== 1'b0 || req_ready !== '0 || rsp_valid !== '0) bad++;
            tick();
        end
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        if (mem_req_valid !== 1'b1 || mem_rsp_ready !== 1'b0) bad++;
        a = mem_addr; we = mem_wen; wd = mem_wdata; wm = mem_wmask;
        if (a !== a0 || wd !== wd0) bad++;
        tick();
        mem_req_ready = 1'b0;
        for (int k = 0; k < rsp_w; k++) begin
            #1;
            if (mem_rsp_ready !== 1'b1 || mem_req_valid !== 1'b0 || rsp_valid !== '0) bad++;
            tick();
        end
        mem_rsp_valid = 1'b1;
        mem_rdata = rd;
        mem_err = er;
        #1;
        if (mem_rsp_ready !== 1'b1) bad++;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rdata = $urandom;
        mem_err = 1'($urandom_range(0, 1));
        for (int k = 0; k < stall; k++) begin
            rsp_ready = ~lane(g);
            #1;
            if (rsp_valid !== lane(g) || rsp_rdata !== rd || rsp_err !== er || req_ready !== '0) bad++;
            tick();
        end
        rsp_ready = lane(g);
        #1;
        rv = rsp_valid; od = rsp_rdata; oe = rsp_err;
        tick();
        rsp_ready = '0;
        req_valid = '0;
        #1;
        if (rsp_valid !== '0 || mem_req_valid !== 1'b0) bad++;
    endtask

    task automatic test_reset();
        logic [N-1:0] rr;
        req_valid = '1;
        #2;
        checks++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, mem_req_valid, mem_addr, mem_wen,
             mem_wdata, mem_wmask, mem_rsp_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req_ready=%b rsp_valid=%b mem_req_valid=%b mem_addr=%h want all 0",
                     req_ready, rsp_valid, mem_req_valid, mem_addr);
        end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        rr = req_ready;
        checks++;
        if (rr !== '0 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: req_ready=%b mem_req_valid=%b want 0/0", rr, mem_req_valid);
        end
        m_ptr = 0;
    endtask

    task automatic test_single_read();
        int g, bad; logic [AW-1:0] a; logic we, oe; logic [DW-1:0] wd, od;
        logic [MW-1:0] wm; logic [N-1:0] rv;
        rand_fields();
        b_addr[0] = 32'h8000_0000;
        b_wen[0]  = 1'b0;
        txn(2'b01, 0, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, g, a, we, wd, wm, rv, od, oe, bad);
        checks++;
        if (g !== 0) begin errors++; $display("FAIL single_grant: got %0d want 0", g); end
        checks++;
        if (a !== 32'h8000_0000 || we !== 1'b0) begin
            errors++; $display("FAIL single_addr: got %h wen %b want 80000000 wen 0", a, we);
        end
        checks++;
        if (rv !== 2'b01 || od !== 32'hDEAD_BEEF || oe !== 1'b0) begin
            errors++; $display("FAIL single_rsp: got lane %b data %h err %b want 01 deadbeef 0", rv, od, oe);
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL single_protocol: got %0d violations want 0", bad); end
        m_ptr = (g + 1) % N;
    endtask

    task automatic test_contention();
        int g, bad, exp; logic [AW-1:0] a, ea; logic we, oe; logic [DW-1:0] wd, od, rd;
        logic [MW-1:0] wm; logic [N-1:0] rv;
        apply_reset();
        for (int t = 0; t < 4; t++) begin
            rand_fields();
            exp = model_pick(m_ptr, 2'b11);
            ea = b_addr[exp];
            rd = $urandom;
            txn(2'b11, 0, 0, 0, rd, 1'b0, 1'b0, g, a, we, wd, wm, rv, od, oe, bad);
            checks++;
            if (g !== exp || g !== (t % 2)) begin
                errors++; $display("FAIL contention_grant[%0d]: got %0d want %0d", t, g, exp);
            end
            checks++;
            if (a !== ea || rv !== lane(exp) || od !== rd || bad !== 0) begin
                errors++;
                $display("FAIL contention_route[%0d]: addr %h lane %b data %h bad %0d want %h %b %h 0",
                         t, a, rv, od, bad, ea, lane(exp), rd);
            end
            m_ptr = (exp + 1) % N;
        end
    endtask

    task automatic test_backpressure();
        int g, bad, exp; logic [AW-1:0] a, ea; logic we, oe; logic [DW-1:0] wd, od, rd;
        logic [MW-1:0] wm; logic [N-1:0] rv;
        rand_fields();
        ea = b_addr[0];
        txn(2'b01, 3, 0, 0, 32'h0BAD_F00D, 1'b0, 1'b1, g, a, we, wd, wm, rv, od, oe, bad);
        checks++;
        if (g !== 0 || a !== ea || rv !== 2'b01 || od !== 32'h0BAD_F00D || bad !== 0) begin
            errors++;
            $display("FAIL bp_req_stall: grant %0d addr %h lane %b data %h bad %0d want 0 %h 01 0badf00d 0",
                     g, a, rv, od, bad, ea);
        end
        m_ptr = 1;
        rand_fields();
        exp = model_pick(m_ptr, 2'b11);
        ea = b_addr[exp];
        rd = $urandom;
        txn(2'b11, 0, 2, 5, rd, 1'b0, 1'b0, g, a, we, wd, wm, rv, od, oe, bad);
        checks++;
        if (g !== exp || g !== 1) begin errors++; $display("FAIL bp_grant: got %0d want %0d", g, exp); end
        checks++;
        if (a !== ea || rv !== 2'b10 || od !== rd || bad !== 0) begin
            errors++;
            $display("FAIL bp_rsp_stall: addr %h lane %b data %h bad %0d want %h 10 %h 0", a, rv, od, bad, ea, rd);
        end
        m_ptr = (exp + 1) % N;
    endtask

    task automatic test_write();
        int g, bad; logic [AW-1:0] a; logic we, oe; logic [DW-1:0] wd, od, rd;
        logic [MW-1:0] wm; logic [N-1:0] rv;
        rand_fields();
        b_addr[REQ_LSU]  = 32'h8000_0010;
        b_wen[REQ_LSU]   = 1'b1;
        b_wdata[REQ_LSU] = 32'h1234_5678;
        b_wmask[REQ_LSU] = 4'b0011;
        rd = $urandom;
        txn(2'b10, 1, 1, 0, rd, 1'b0, 1'b0, g, a, we, wd, wm, rv, od, oe, bad);
        checks++;
        if (g !== REQ_LSU || a !== 32'h8000_0010 || we !== 1'b1 || wd !== 32'h1234_5678 || wm !== 4'b0011) begin
            errors++;
            $display("FAIL write_fields: grant %0d addr %h wen %b data %h mask %b want 1 80000010 1 12345678 0011",
                     g, a, we, wd, wm);
        end
        checks++;
        if (rv !== 2'b10 || od !== rd || bad !== 0) begin
            errors++; $display("FAIL write_rsp: lane %b data %h bad %0d want 10 %h 0", rv, od, bad, rd);
        end
        m_ptr = (REQ_LSU + 1) % N;
    endtask

    task automatic test_error();
        int g, bad; logic [AW-1:0] a; logic we, oe; logic [DW-1:0] wd, od;
        logic [MW-1:0] wm; logic [N-1:0] rv;
        rand_fields();
        txn(2'b01, 0, 0, 2, 32'hFFFF_0000, 1'b1, 1'b0, g, a, we, wd, wm, rv, od, oe, bad);
        checks++;
        if (oe !== 1'b1 || rv !== 2'b01 || g !== REQ_IFU || bad !== 0) begin
            errors++; $display("FAIL error_rsp: err %b lane %b grant %0d bad %0d want 1 01 0 0", oe, rv, g, bad);
        end
        m_ptr = (REQ_IFU + 1) % N;
    endtask

    task automatic test_random();
        int g, bad, exp; logic [AW-1:0] a, ea; logic we, oe, ewe, er; logic [DW-1:0] wd, od, rd, ewd;
        logic [MW-1:0] wm, ewm; logic [N-1:0] rv, vld;
        for (int t = 0; t < 40; t++) begin
            rand_fields();
            vld = N'($urandom_range(1, (1 << N) - 1));
            exp = model_pick(m_ptr, vld);
            ea = b_addr[exp]; ewe = b_wen[exp]; ewd = b_wdata[exp]; ewm = b_wmask[exp];
            rd = $urandom;
            er = 1'($urandom_range(0, 1));
            txn(vld, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), rd, er,
                1'($urandom_range(0, 1)), g, a, we, wd, wm, rv, od, oe, bad);
            checks++;
            if (g !== exp) begin
                errors++; $display("FAIL rand_grant[%0d]: vld %b got %0d want %0d", t, vld, g, exp);
            end
            checks++;
            if (a !== ea || we !== ewe || wd !== ewd || wm !== ewm) begin
                errors++;
                $display("FAIL rand_fields[%0d]: %h %b %h %b want %h %b %h %b", t, a, we, wd, wm, ea, ewe, ewd, ewm);
            end
            checks++;
            if (rv !== lane(exp) || od !== rd || oe !== er || bad !== 0) begin
                errors++;
                $display("FAIL rand_rsp[%0d]: lane %b data %h err %b bad %0d want %b %h %b 0",
                         t, rv, od, oe, bad, lane(exp), rd, er);
            end
            m_ptr = (exp + 1) % N;
        end
    endtask

    task automatic test_async_reset();
        int g, bad; logic [AW-1:0] a; logic we, oe; logic [DW-1:0] wd, od;
        logic [MW-1:0] wm; logic [N-1:0] rv;
        apply_reset();
        rand_fields();
        req_valid = 2'b10;
        tick();
        req_valid = '0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #1;
        checks++;
        if (mem_rsp_ready !== 1'b1) begin
            errors++; $display("FAIL areset_in_wait: mem_rsp_ready %b want 1", mem_rsp_ready);
        end
        req_valid = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, mem_req_valid, mem_addr, mem_wen,
             mem_wdata, mem_wmask, mem_rsp_ready} !== '0) begin
            errors++;
            $display("FAIL areset_outputs: req_ready=%b mem_rsp_ready=%b mem_addr=%h want all 0",
                     req_ready, mem_rsp_ready, mem_addr);
        end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        m_ptr = 0;
        rand_fields();
        txn(2'b11, 0, 0, 0, 32'h5555_AAAA, 1'b0, 1'b0, g, a, we, wd, wm, rv, od, oe, bad);
        checks++;
        if (g !== model_pick(m_ptr, 2'b11) || rv !== 2'b01 || od !== 32'h5555_AAAA || bad !== 0) begin
            errors++; $display("FAIL areset_next_grant: grant %0d lane %b bad %0d want 0 01 0", g, rv, bad);
        end
    endtask

    initial begin
        for (int n = 0; n < N; n++) begin
            b_addr[n] = '0; b_wen[n] = 1'b0; b_wdata[n] = '0; b_wmask[n] = '0;
        end
        test_reset();
        test_single_read();
        test_contention();
        test_backpressure();
        test_write();
        test_error();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
